// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the memory arbiter and anything that talks to it:
//   arb_state_t : 2-bit FSM state encoding (IDLE, GRANT_I, GRANT_D, DONE)
//   REQ_I/REQ_D : requester IDs (instruction side = 0, data side = 1)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer
// Wait-state counter for one granted memory access.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset
//   clear   : restart the count (asserted on the grant edge)
//   enable  : count this cycle (a GRANT cycle without mem_ready)
//   expired : this enabled cycle brings the count to TIMEOUT
// TIMEOUT is expected to be at least 1.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Looks one step ahead so the FSM leaves GRANT on the edge where the
    // count would reach TIMEOUT. enable is gated by mem_ready upstream, so a
    // late mem_ready on that same cycle wins over the timeout.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port (read only) and a data port
// (read/write) onto one shared single-port memory. D has priority, but
// after D_STREAK_MAX consecutive D grants with I waiting, I is granted.
// All memory-side outputs are registered.
//   clock, reset                     : clock, async active-low reset
//   i_req, i_addr                    : fetch request / address
//   i_ack, i_rdata, i_err            : fetch done pulse, data, timeout flag
//   d_req, d_we, d_addr, d_wdata     : data request / write enable / addr / data
//   d_ack, d_rdata, d_err            : data done pulse, data, timeout flag
//   mem_req, mem_we, mem_addr, mem_wdata : shared memory request
//   mem_ready, mem_rdata             : memory completion strobe / read data
//   halt                             : a request is pending and not yet acked
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned D_STREAK_MAX = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halt
);

    localparam int unsigned SW = (D_STREAK_MAX < 2) ? 1 : $clog2(D_STREAK_MAX + 1);

    arb_state_t    state, state_n;
    logic [SW-1:0] streak;
    logic          grant_i, grant_d, finish;
    logic          in_grant, expired;

    assign in_grant = (state == GRANT_I) || (state == GRANT_D);

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (grant_i | grant_d),
        .enable  (in_grant & ~mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || streak != SW'(D_STREAK_MAX))) begin
                    grant_d = 1'b1;
                    state_n = GRANT_D;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_n = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready || expired) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            streak    <= '0;
        end else begin
            // Acks and error flags are one-cycle pulses in DONE.
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;

            if (grant_i || grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= grant_d & d_we;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
            end

            if (finish) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                // finish without mem_ready can only come from the timer.
                if (state == GRANT_D) begin
                    d_ack <= 1'b1;
                    d_err <= ~mem_ready;
                    if (mem_ready) d_rdata <= mem_rdata;
                end else begin
                    i_ack <= 1'b1;
                    i_err <= ~mem_ready;
                    if (mem_ready) i_rdata <= mem_rdata;
                end
            end

            if (state == IDLE) begin
                if (!i_req || grant_i) begin
                    streak <= '0;
                end else if (grant_d) begin
                    streak <= streak + SW'(1);
                end
            end
        end
    end

    assign halt = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
